// File: rtl/buf_seq.sv
// rtl/buf_seq.sv - fill/drain sequencer for the 3D FFT transpose buffer
module buf_seq #(
  parameter int CUBIC_D = 96,
  parameter int PAIRS   = CUBIC_D / 2,
  parameter int RD_LAT  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       rd_ready,
  output logic       mem_wr,
  output logic       mem_rd,
  output logic [6:0] row_no,
  output logic [6:0] col_no,
  output logic [6:0] dep_no,
  output logic       out_valid,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  localparam logic [6:0] ROW_T   = 7'(PAIRS - 1);
  localparam logic [6:0] CD_T    = 7'(CUBIC_D - 1);
  localparam logic [7:0] DRAIN_T = 8'(RD_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [6:0]        row_q, row_d, col_q, col_d, dep_q, dep_d;
  logic [7:0]        drain_q, drain_d;
  logic [RD_LAT-1:0] vld_q, lst_q;
  logic              last_rd;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      dep_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dep_q   <= dep_d;
      drain_q <= drain_d;
    end
  end

  // Tag pipeline matches the RAM read latency; it keeps shifting in every state.
  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clock) begin
        if (!reset) begin
          vld_q <= '0;
          lst_q <= '0;
        end else begin
          vld_q <= mem_rd;
          lst_q <= last_rd;
        end
      end
    end else begin : g_latn
      always_ff @(posedge clock) begin
        if (!reset) begin
          vld_q <= '0;
          lst_q <= '0;
        end else begin
          vld_q <= {vld_q[RD_LAT-2:0], mem_rd};
          lst_q <= {lst_q[RD_LAT-2:0], last_rd};
        end
      end
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    dep_d    = dep_q;
    drain_d  = drain_q;
    wr_ready = 1'b0;
    mem_wr   = 1'b0;
    mem_rd   = 1'b0;
    last_rd  = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          row_d   = '0;
          col_d   = '0;
          dep_d   = '0;
        end
      end
      S_WRITE: begin
        wr_ready = 1'b1;
        mem_wr   = wr_valid;
        // Write order: col fastest, then dep, then row pair.
        if (wr_valid) begin
          if (col_q == CD_T) begin
            col_d = '0;
            if (dep_q == CD_T) begin
              dep_d = '0;
              if (row_q == ROW_T) begin
                row_d   = '0;
                state_d = S_READ;
              end else begin
                row_d = row_q + 7'd1;
              end
            end else begin
              dep_d = dep_q + 7'd1;
            end
          end else begin
            col_d = col_q + 7'd1;
          end
        end
      end
      S_READ: begin
        mem_rd = rd_ready;
        // Transposed order: row pair fastest, then col, then dep.
        if (rd_ready) begin
          if (row_q == ROW_T) begin
            row_d = '0;
            if (col_q == CD_T) begin
              col_d = '0;
              if (dep_q == CD_T) begin
                dep_d   = '0;
                last_rd = 1'b1;
                drain_d = '0;
                state_d = S_DRAIN;
              end else begin
                dep_d = dep_q + 7'd1;
              end
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            row_d = row_q + 7'd1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_T) begin
          drain_d = '0;
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign row_no    = row_q;
  assign col_no    = col_q;
  assign dep_no    = dep_q;
  assign out_valid = vld_q[RD_LAT-1];
  assign out_last  = lst_q[RD_LAT-1];

endmodule

// File: tb/tb_buf_seq.sv
// tb/tb_buf_seq.sv - scoreboard bench for buf_seq on a reduced cube
module tb_buf_seq;
  localparam int D = 6;
  localparam int P = 3;
  localparam int L = 2;
  localparam int N = P * D * D;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       wr_valid = 1'b0;
  logic       rd_ready = 1'b0;
  logic       wr_ready, mem_wr, mem_rd, out_valid, out_last, busy, done;
  logic [6:0] row_no, col_no, dep_no;

  always #5 clock = ~clock;

  buf_seq #(.CUBIC_D(D), .PAIRS(P), .RD_LAT(L)) dut (
    .clock(clock), .reset(reset), .start(start), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_ready(rd_ready), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .row_no(row_no), .col_no(col_no), .dep_no(dep_no), .out_valid(out_valid),
    .out_last(out_last), .busy(busy), .done(done)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [20:0] exp_wr[$];
  logic [20:0] exp_rd[$];
  logic        exp_last[$];
  int          cyc_g = 0;
  int          first_wr = -1;
  int          last_wr = -1;
  int          rd_seen = 0;
  int          done_cnt = 0;
  bit          mon_en = 1'b0;
  bit          gap_flag = 1'b0;
  logic [L-1:0] hist = '0;
  logic        prev_rst = 1'b0;
  logic        prev_strobe = 1'b0;
  logic [20:0] prev_coord = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc_g);
    end
  endtask

  // Reference orders straight from the buffer layout: writes walk col, dep, row;
  // reads walk row, col, dep; only the very last read carries the last flag.
  task automatic push_frame();
    for (int r = 0; r < P; r++)
      for (int d = 0; d < D; d++)
        for (int c = 0; c < D; c++)
          exp_wr.push_back({7'(r), 7'(c), 7'(d)});
    for (int d = 0; d < D; d++)
      for (int c = 0; c < D; c++)
        for (int r = 0; r < P; r++)
          exp_rd.push_back({7'(r), 7'(c), 7'(d)});
    for (int i = 0; i < N; i++)
      exp_last.push_back(i == N - 1);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    push_frame();
    first_wr = -1;
    last_wr  = -1;
    rd_seen  = 0;
    tick();
    start = 1'b0;
  endtask

  always @(posedge clock) cyc_g++;

  always @(negedge clock) begin
    if (mon_en) begin
      logic [20:0] coord;
      logic        el;
      coord = {row_no, col_no, dep_no};
      chk("strobe_excl", 32'(mem_wr & mem_rd), 0);
      if (prev_rst && !prev_strobe) chk("coord_hold", 32'(coord), 32'(prev_coord));
      if (gap_flag) chk("gap_rd", 32'(mem_rd), 0);
      if (mem_wr) begin
        chk("wr_gated", 32'({wr_valid, wr_ready}), 3);
        if (first_wr < 0) first_wr = cyc_g;
        last_wr = cyc_g;
        if (exp_wr.size() == 0) chk("wr_extra", 1, 0);
        else chk("wr_coord", 32'(coord), 32'(exp_wr.pop_front()));
      end
      if (mem_rd) begin
        rd_seen++;
        if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_coord", 32'(coord), 32'(exp_rd.pop_front()));
      end
      chk("out_valid_lat", 32'(out_valid), 32'(hist[L-1]));
      if (out_valid) begin
        if (exp_last.size() == 0) chk("out_extra", 1, 0);
        else begin
          el = exp_last.pop_front();
          chk("out_last", 32'(out_last), 32'(el));
        end
      end else begin
        chk("out_last_idle", 32'(out_last), 0);
      end
      if (done) done_cnt++;
      hist = reset ? {hist[L-2:0], mem_rd} : '0;
      prev_rst    = reset;
      prev_strobe = mem_wr | mem_rd;
      prev_coord  = coord;
    end
  end

  // mode 0: always ready; 1: random handshakes plus stray starts; 2: toggled wr_valid and a 5-cycle read gap
  task automatic run_frame(input int mode, output int cyc);
    bit wv = 1'b1;
    int gap = 0;
    bit gap_done = 1'b0;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    do_start();
    chk("busy_after_start", 32'({busy, wr_ready}), 3);
    cyc = 1;
    while (!done && cyc < 4 * N + 100) begin
      case (mode)
        1: begin
          wr_valid = 1'($urandom_range(0, 1));
          rd_ready = ($urandom_range(0, 3) != 0);
          start    = busy && ($urandom_range(0, 15) == 0);
        end
        2: begin
          wr_valid = wv;
          wv = ~wv;
          if (!gap_done && rd_seen >= 20) begin
            gap = 5;
            gap_done = 1'b1;
          end
          rd_ready = (gap == 0);
          gap_flag = (gap != 0);
          if (gap > 0) gap--;
        end
        default: ;
      endcase
      tick();
      cyc++;
    end
    start = 1'b0;
    gap_flag = 1'b0;
    chk("done_seen", 32'(done), 1);
    chk("wr_queue_empty", 32'(exp_wr.size()), 0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 0);
    chk("out_queue_empty", 32'(exp_last.size()), 0);
    tick();
    chk("busy_fall", 32'({busy, done}), 0);
  endtask

  initial begin
    int cyc;
    int dc;
    reset = 1'b0;
    repeat (3) tick();
    chk("reset_outs", 32'({wr_ready, mem_wr, mem_rd, busy, done, out_valid, out_last,
                           row_no, col_no, dep_no}), 0);
    reset = 1'b1;
    mon_en = 1'b1;
    tick();
    chk("idle_outs", 32'({busy, done, wr_ready}), 0);

    run_frame(0, cyc);
    chk("done_cycle", 32'(cyc), 32'(2 * N + 3));
    chk("wr_span_full", 32'(last_wr - first_wr + 1), 32'(N));

    run_frame(1, cyc);
    repeat (3) begin
      tick();
      chk("no_restart", 32'(busy), 0);
    end

    run_frame(2, cyc);
    chk("wr_span_toggle", 32'(last_wr - first_wr + 1), 32'(2 * N - 1));

    wr_valid = 1'b1;
    rd_ready = 1'b1;
    do_start();
    cyc = 0;
    while (!(busy && !wr_ready && row_no == 7'd1 && col_no == 7'd2 && dep_no == 7'd3)
           && cyc < 4 * N) begin
      tick();
      cyc++;
    end
    chk("reach_target", 32'(cyc < 4 * N), 1);
    dc = done_cnt;
    reset = 1'b0;
    tick();
    chk("midread_reset_outs", 32'({wr_ready, mem_wr, mem_rd, busy, done, out_valid, out_last,
                                   row_no, col_no, dep_no}), 0);
    reset = 1'b1;
    exp_wr.delete();
    exp_rd.delete();
    exp_last.delete();
    repeat (4) begin
      tick();
      chk("pipe_empty", 32'({out_valid, busy}), 0);
    end
    chk("no_done_on_reset", 32'(done_cnt), 32'(dc));

    run_frame(1, cyc);
    chk("frames_done", 32'(done_cnt), 32'(dc + 1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
